// File: rtl/systolic_pkg.sv
// Shared state encoding and default dimensions for the systolic matmul slice.
package systolic_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefDim       = 8;
  localparam int unsigned DefAddrWidth = 10;
  localparam int unsigned DefTimeout   = 1024;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFeed  = 3'd1,
    StWait  = 3'd2,
    StStore = 3'd3,
    StFin   = 3'd4
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/addr_gen.sv
// BRAM address generator: base plus offset, wrapping modulo 2^ADDR_WIDTH.
module addr_gen #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_off,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  assign o_addr = i_base + i_off;

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one matmul job: feeds A/B from BRAM, waits for the multiplier, stores C.
// Owns the BRAM ports whenever a job is in flight; the host drives them only in IDLE.
module matmul_sequencer
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned M          = DefDim,
  parameter int unsigned N          = DefDim,
  parameter int unsigned P          = DefDim,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] base_c,
  input  logic                  host_we_a,
  input  logic                  host_we_b,
  input  logic [ADDR_WIDTH-1:0] host_addr_a,
  input  logic [ADDR_WIDTH-1:0] host_addr_b,
  input  logic [ADDR_WIDTH-1:0] host_addr_c,
  output logic                  we_a,
  output logic                  we_b,
  output logic                  we_c,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [ADDR_WIDTH-1:0] addr_c,
  output logic                  mm_start,
  input  logic                  mm_done,
  output logic                  host_err
);

  localparam int unsigned MN    = M * N;
  localparam int unsigned NP    = N * P;
  localparam int unsigned MP    = M * P;
  localparam int unsigned K     = max_u(MN, NP);
  localparam int unsigned CNT_W = $clog2(max_u(max_u(K, MP), TIMEOUT) + 1);

  localparam logic [CNT_W-1:0] CntFeedLast  = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] CntStoreLast = CNT_W'(MP - 1);
  localparam logic [CNT_W-1:0] CntWaitLast  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntALast     = CNT_W'(MN - 1);
  localparam logic [CNT_W-1:0] CntBLast     = CNT_W'(NP - 1);

  seq_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_base_a, w_base_a_nxt;
  logic [ADDR_WIDTH-1:0] r_base_b, w_base_b_nxt;
  logic [ADDR_WIDTH-1:0] r_base_c, w_base_c_nxt;
  logic                  r_err, w_err_nxt;

  logic [CNT_W-1:0]      w_off_a, w_off_b;
  logic [ADDR_WIDTH-1:0] w_addr_a, w_addr_b, w_addr_c;
  logic                  w_idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_c <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_base_a <= w_base_a_nxt;
      r_base_b <= w_base_b_nxt;
      r_base_c <= w_base_c_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_base_a_nxt = r_base_a;
    w_base_b_nxt = r_base_b;
    w_base_c_nxt = r_base_c;
    w_err_nxt    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (go) begin
          w_base_a_nxt = base_a;
          w_base_b_nxt = base_b;
          w_base_c_nxt = base_c;
          w_cnt_nxt    = '0;
          w_state_nxt  = StFeed;
        end
      end
      StFeed: begin
        // mm_done is deliberately not looked at while feeding
        if (r_cnt == CntFeedLast) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StWait;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      StWait: begin
        if (mm_done) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StStore;
        end else if (r_cnt == CntWaitLast) begin
          // err lands on the first IDLE cycle, TIMEOUT cycles after WAIT entry
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      StStore: begin
        if (r_cnt == CntStoreLast) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StFin;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      StFin: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Shorter operand holds its last element while the longer one finishes
  assign w_off_a = (r_cnt > CntALast) ? CntALast : r_cnt;
  assign w_off_b = (r_cnt > CntBLast) ? CntBLast : r_cnt;

  addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen_a (
    .i_base(r_base_a),
    .i_off (ADDR_WIDTH'(w_off_a)),
    .o_addr(w_addr_a)
  );

  addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen_b (
    .i_base(r_base_b),
    .i_off (ADDR_WIDTH'(w_off_b)),
    .o_addr(w_addr_b)
  );

  addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen_c (
    .i_base(r_base_c),
    .i_off (ADDR_WIDTH'(r_cnt)),
    .o_addr(w_addr_c)
  );

  assign w_idle   = (r_state == StIdle);
  assign busy     = !w_idle;
  assign done     = (r_state == StFin);
  assign err      = r_err;
  assign mm_start = (r_state == StFeed) && (r_cnt == '0);
  assign host_err = !w_idle && (host_we_a || host_we_b);

  assign we_a   = w_idle && host_we_a;
  assign we_b   = w_idle && host_we_b;
  assign we_c   = (r_state == StStore);
  assign addr_a = w_idle ? host_addr_a : w_addr_a;
  assign addr_b = w_idle ? host_addr_b : w_addr_b;
  assign addr_c = w_idle ? host_addr_c : w_addr_c;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with an address scoreboard for the A/B/C paths.
module tb_matmul_sequencer;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst, go, host_we_a, host_we_b, mm_done;
  logic [AW-1:0] base_a, base_b, base_c, host_addr_a, host_addr_b, host_addr_c;
  logic          busy, done, err, we_a, we_b, we_c, mm_start, host_err;
  logic [AW-1:0] addr_a, addr_b, addr_c;

  logic          d2_go, d2_mm_done;
  logic          d2_zero = 1'b0;
  logic [AW-1:0] d2_zero_addr = '0;
  logic [AW-1:0] d2_base_a, d2_base_b, d2_base_c;
  logic          d2_busy, d2_done, d2_err, d2_we_a, d2_we_b, d2_we_c, d2_mm_start, d2_host_err;
  logic [AW-1:0] d2_addr_a, d2_addr_b, d2_addr_c;

  int unsigned checks = 0, errors = 0;
  int unsigned n_done = 0, n_err = 0, n_start = 0, n_herr = 0, n_wec = 0;
  int unsigned q_a[$], q_b[$], q_c[$];

  always #5 clk = ~clk;

  matmul_sequencer u_dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .err(err),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .host_we_a(host_we_a), .host_we_b(host_we_b),
    .host_addr_a(host_addr_a), .host_addr_b(host_addr_b), .host_addr_c(host_addr_c),
    .we_a(we_a), .we_b(we_b), .we_c(we_c),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .mm_start(mm_start), .mm_done(mm_done), .host_err(host_err)
  );

  matmul_sequencer #(.M(4), .N(2), .P(6)) u_dut2 (
    .clk(clk), .rst(rst), .go(d2_go), .busy(d2_busy), .done(d2_done), .err(d2_err),
    .base_a(d2_base_a), .base_b(d2_base_b), .base_c(d2_base_c),
    .host_we_a(d2_zero), .host_we_b(d2_zero),
    .host_addr_a(d2_zero_addr), .host_addr_b(d2_zero_addr), .host_addr_c(d2_zero_addr),
    .we_a(d2_we_a), .we_b(d2_we_b), .we_c(d2_we_c),
    .addr_a(d2_addr_a), .addr_b(d2_addr_b), .addr_c(d2_addr_c),
    .mm_start(d2_mm_start), .mm_done(d2_mm_done), .host_err(d2_host_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // C-port scoreboard and event counters for the default-size DUT
  always @(negedge clk) begin
    if (we_c === 1'b1) begin
      n_wec++;
      checks++;
      assert (q_c.size() != 0)
      else begin
        errors++;
        $error("FAIL addr_c_unexpected: observed write at %0d expected none", addr_c);
      end
      if (q_c.size() != 0) chk("addr_c", 32'(addr_c), q_c.pop_front());
    end
    if (done === 1'b1) n_done++;
    if (err === 1'b1) n_err++;
    if (mm_start === 1'b1) n_start++;
    if (host_err === 1'b1) n_herr++;
  end

  // Issue go, then check every FEED cycle against the pushed expectations
  task automatic job_feed(input bit sel, input int unsigned ba, input int unsigned bb,
                          input int unsigned bc, input int unsigned mn, input int unsigned np,
                          input int unsigned lo, input int unsigned hi);
    int unsigned kk;
    bit          hv;
    kk = (mn > np) ? mn : np;
    for (int unsigned k = 0; k < kk; k++) begin
      q_a.push_back((ba + ((k < mn - 1) ? k : mn - 1)) % 1024);
      q_b.push_back((bb + ((k < np - 1) ? k : np - 1)) % 1024);
    end
    if (sel) begin
      d2_base_a = AW'(ba); d2_base_b = AW'(bb); d2_base_c = AW'(bc); d2_go = 1'b1;
    end else begin
      base_a = AW'(ba); base_b = AW'(bb); base_c = AW'(bc); go = 1'b1;
    end
    step();
    go = 1'b0;
    d2_go = 1'b0;
    for (int unsigned k = 0; k < kk; k++) begin
      hv = !sel && (k >= lo) && (k < hi);
      host_we_a = hv;
      @(negedge clk);
      chk("feed_addr_a", 32'(sel ? d2_addr_a : addr_a), q_a.pop_front());
      chk("feed_addr_b", 32'(sel ? d2_addr_b : addr_b), q_b.pop_front());
      chk("mm_start", 32'(sel ? d2_mm_start : mm_start), 32'(k == 0));
      if (!sel) begin
        chk("feed_we_a", 32'(we_a), 0);
        chk("feed_host_err", 32'(host_err), 32'(hv));
      end
      step();
    end
    host_we_a = 1'b0;
  endtask

  task automatic pulse_mm_done();
    mm_done = 1'b1;
    step();
    mm_done = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned d0;
    int unsigned i;
    d0 = n_done;
    i  = 0;
    while (n_done == d0 && i < budget) begin
      step();
      i++;
    end
    chk("done_seen", n_done - d0, 1);
  endtask

  initial begin
    int          c;
    int unsigned d0, e0, w0, n2_wec, n2_done;

    rst = 1'b1; go = 1'b0; mm_done = 1'b0; host_we_a = 1'b0; host_we_b = 1'b0;
    base_a = '0; base_b = '0; base_c = '0;
    host_addr_a = '0; host_addr_b = '0; host_addr_c = '0;
    d2_go = 1'b0; d2_mm_done = 1'b0; d2_base_a = '0; d2_base_b = '0; d2_base_c = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mm_start", 32'(mm_start), 0);
    chk("rst_we_c", 32'(we_c), 0);
    go = 1'b1;
    repeat (3) step();
    chk("rst_go_ignored", 32'(busy), 0);
    go = 1'b0;
    rst = 1'b1;
    step();

    // IDLE pass-through is combinational
    host_addr_a = 10'd5; host_addr_b = 10'd7; host_addr_c = 10'd9; host_we_a = 1'b1;
    #1;
    chk("idle_addr_a", 32'(addr_a), 5);
    chk("idle_we_a", 32'(we_a), 1);
    chk("idle_addr_b", 32'(addr_b), 7);
    chk("idle_addr_c", 32'(addr_c), 9);
    chk("idle_we_c", 32'(we_c), 0);
    chk("idle_host_err", 32'(host_err), 0);
    host_we_a = 1'b0;
    step();

    // Job 1: full run, host write attempts during FEED, stray go in WAIT
    job_feed(1'b0, 0, 64, 128, 64, 64, 3, 6);
    chk("wait_busy", 32'(busy), 1);
    repeat (10) step();
    go = 1'b1;
    step();
    go = 1'b0;
    repeat (110) step();
    for (int unsigned j = 0; j < 64; j++) q_c.push_back(128 + j);
    pulse_mm_done();
    wait_done(100);
    chk("fin_busy_low", 32'(busy), 0);
    repeat (5) step();
    chk("job1_wec", n_wec, 64);
    chk("job1_qc_empty", q_c.size(), 0);
    chk("job1_starts", n_start, 1);
    chk("job1_host_err", n_herr, 3);
    chk("job1_done_once", n_done, 1);

    // Job 2: no mm_done, timeout
    w0 = n_wec;
    job_feed(1'b0, 0, 64, 128, 64, 64, 0, 0);
    for (c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (err === 1'b1) break;
      step();
    end
    chk("err_latency", c, 1024);
    step();
    @(negedge clk);
    chk("err_busy_low", 32'(busy), 0);
    chk("err_one_cycle", 32'(err), 0);
    chk("err_count", n_err, 1);
    chk("err_no_wec", n_wec - w0, 0);
    step();

    // Job 3: addr_c wraps past 1023
    w0 = n_wec;
    job_feed(1'b0, 0, 64, 1000, 64, 64, 0, 0);
    for (int unsigned j = 0; j < 64; j++) q_c.push_back((1000 + j) % 1024);
    pulse_mm_done();
    wait_done(100);
    chk("wrap_wec", n_wec - w0, 64);
    chk("wrap_qc_empty", q_c.size(), 0);

    // Job 4: reset at STORE j=10
    d0 = n_done; e0 = n_err;
    job_feed(1'b0, 0, 64, 200, 64, 64, 0, 0);
    for (int unsigned j = 0; j < 10; j++) q_c.push_back(200 + j);
    pulse_mm_done();
    repeat (10) step();
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_we_c", 32'(we_c), 0);
    chk("abort_done", 32'(done), 0);
    repeat (5) step();
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_no_err", n_err - e0, 0);
    chk("abort_qc_empty", q_c.size(), 0);
    rst = 1'b1;
    step();

    // Job 5: fresh job after abort
    w0 = n_wec;
    job_feed(1'b0, 16, 80, 300, 64, 64, 0, 0);
    repeat (3) step();
    for (int unsigned j = 0; j < 64; j++) q_c.push_back(300 + j);
    pulse_mm_done();
    wait_done(100);
    chk("rerun_wec", n_wec - w0, 64);
    chk("total_starts", n_start, 5);

    // Non-square DUT: A holds at base+7 for k=8..11
    job_feed(1'b1, 10, 20, 30, 8, 12, 0, 0);
    d2_mm_done = 1'b1;
    step();
    d2_mm_done = 1'b0;
    n2_wec = 0;
    n2_done = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d2_we_c === 1'b1) n2_wec++;
      if (d2_done === 1'b1) n2_done++;
      step();
    end
    chk("d2_wec", n2_wec, 24);
    chk("d2_done", n2_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
